// File: rtl/clocking_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clocking_pkg
// Purpose  : Shared types and constants for the clocking reconfiguration
//            sequencer. It holds the FSM state encoding, the configuration
//            record, the counter width and the parameter defaults.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package clocking_pkg;

  localparam int CNT_W = 10;

  localparam int unsigned DFLT_HOLD_CYCLES   = 4;
  localparam int unsigned DFLT_SETTLE_CYCLES = 8;
  localparam int unsigned DFLT_LOCK_TIMEOUT  = 1023;
  localparam logic [2:0]  DFLT_SEL           = 3'd1;
  localparam logic [2:0]  DFLT_SEL2          = 3'd1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_HOLD      = 3'd2,
    ST_APPLY     = 3'd3,
    ST_SETTLE    = 3'd4,
    ST_RELEASE   = 3'd5
  } state_t;

  // One clocking configuration as seen by the clocking block.
  typedef struct packed {
    logic       ext_sel;
    logic [2:0] sel;
    logic [2:0] sel2;
  } clk_cfg_t;

endpackage
`default_nettype wire

// File: rtl/sync2.sv
`default_nettype none
// ============================================================================
// Module   : sync2
// Purpose  : Two-flop synchronizer for a single asynchronous level.
// Ports    : clk          - destination clock
//            resetb_async - asynchronous active-low reset, output resets to 0
//            d            - asynchronous input level
//            q            - synchronized level, two clk cycles of latency
// Revision : 1.0 - initial release
// ============================================================================
module sync2 (
  input  logic clk,
  input  logic resetb_async,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge resetb_async) begin
    if (!resetb_async) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule
`default_nettype wire

// File: rtl/clocking_reconfig_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clocking_reconfig_ctrl
// Purpose  : Applies run-time clocking configuration requests with a
//            gate / apply / settle sequence so divided clocks never glitch
//            and the core never switches onto an unlocked PLL.
// Ports    : pll_clk, resetb_async      - clock, async active-low reset
//            req_valid/req_ready        - request handshake (ready in IDLE)
//            req_ext_sel/req_sel/req_sel2 - requested configuration
//            pll_lock                   - asynchronous PLL lock
//            ext_clk_sel_out/sel_out/sel2_out - configuration to clocking block
//            clk_hold                   - core/user clock gate request
//            div_restart_n              - divider restart, low in APPLY only
//            busy/done/err              - sequencer status
// Revision : 1.0 - initial release
// ============================================================================
module clocking_reconfig_ctrl
  import clocking_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES   = DFLT_HOLD_CYCLES,
  parameter int unsigned SETTLE_CYCLES = DFLT_SETTLE_CYCLES,
  parameter int unsigned LOCK_TIMEOUT  = DFLT_LOCK_TIMEOUT,
  parameter logic [2:0]  DEF_SEL       = DFLT_SEL,
  parameter logic [2:0]  DEF_SEL2      = DFLT_SEL2
) (
  input  logic       pll_clk,
  input  logic       resetb_async,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_ext_sel,
  input  logic [2:0] req_sel,
  input  logic [2:0] req_sel2,
  input  logic       pll_lock,
  output logic       ext_clk_sel_out,
  output logic [2:0] sel_out,
  output logic [2:0] sel2_out,
  output logic       clk_hold,
  output logic       div_restart_n,
  output logic       busy,
  output logic       done,
  output logic       err
);

  // Counter reload values: residency length minus one.
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LD   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam clk_cfg_t RST_CFG = '{ext_sel: 1'b1, sel: DEF_SEL, sel2: DEF_SEL2};

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             lock_s;
  clk_cfg_t         req_cfg, pend, cur;
  logic             accept, noop, timeout, finish;

  sync2 u_lock_sync (
    .clk          (pll_clk),
    .resetb_async (resetb_async),
    .d            (pll_lock),
    .q            (lock_s)
  );

  assign req_cfg   = '{ext_sel: req_ext_sel, sel: req_sel, sel2: req_sel2};
  assign req_ready = (state == ST_IDLE);

  assign ext_clk_sel_out = cur.ext_sel;
  assign sel_out         = cur.sel;
  assign sel2_out        = cur.sel2;

  always_ff @(posedge pll_clk or negedge resetb_async) begin
    if (!resetb_async) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    // Saturating decrement: the counter parks at zero instead of wrapping.
    cnt_nxt   = (cnt != '0) ? cnt - 1'b1 : cnt;
    accept    = 1'b0;
    noop      = 1'b0;
    timeout   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (req_cfg == cur) begin
            noop = 1'b1;
          end else if (!req_ext_sel && !lock_s) begin
            state_nxt = ST_WAIT_LOCK;
            cnt_nxt   = LOCK_LD;
          end else begin
            state_nxt = ST_HOLD;
            cnt_nxt   = HOLD_LD;
          end
        end
      end
      ST_WAIT_LOCK: begin
        // Lock takes priority even on the final counted cycle.
        if (lock_s) begin
          state_nxt = ST_HOLD;
          cnt_nxt   = HOLD_LD;
        end else if (cnt == '0) begin
          state_nxt = ST_IDLE;
          timeout   = 1'b1;
        end
      end
      ST_HOLD: begin
        if (cnt == '0) begin
          state_nxt = ST_APPLY;
          cnt_nxt   = '0;
        end
      end
      ST_APPLY: begin
        state_nxt = ST_SETTLE;
        cnt_nxt   = SETTLE_LD;
      end
      ST_SETTLE: begin
        if (cnt == '0) begin
          state_nxt = ST_RELEASE;
          cnt_nxt   = '0;
        end
      end
      ST_RELEASE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign finish = noop | timeout | (state_nxt == ST_RELEASE);

  // Status and strobes are registered from the next state so clk_hold and
  // div_restart_n come straight from flops and cannot glitch on decode.
  always_ff @(posedge pll_clk or negedge resetb_async) begin
    if (!resetb_async) begin
      pend          <= RST_CFG;
      cur           <= RST_CFG;
      clk_hold      <= 1'b0;
      div_restart_n <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      if (accept) begin
        pend <= req_cfg;
      end
      if (state == ST_APPLY) begin
        cur <= pend;
      end
      clk_hold      <= (state_nxt == ST_HOLD) || (state_nxt == ST_APPLY) ||
                       (state_nxt == ST_SETTLE);
      div_restart_n <= (state_nxt != ST_APPLY);
      busy          <= (state_nxt != ST_IDLE);
      done          <= finish;
      if (finish) begin
        err <= timeout;
      end
    end
  end

endmodule
`default_nettype wire
